// File: rtl/shift_sequencer_if.sv
// Handshake bundle between the requesters / response consumer and the shared
// shift sequencer.
//   req_valid/req_ready : per-requester command handshake (ready is one-hot or zero)
//   req_data/op/amt     : packed per-requester operand, opcode and shift amount
//   rsp_valid/rsp_ready : single response channel handshake
//   rsp_data/rsp_id     : shifted result and index of the issuing requester
// master = requester/consumer side, slave = sequencer side.
interface shift_sequencer_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ*3-1:0] req_amt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_data, req_op, req_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_op, req_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/shift_sequencer.sv
// Shared iterative shift engine for NREQ requesters.
// Commands are arbitrated round-robin, executed one bit position per cycle,
// and the result is returned on one response channel tagged with the
// requester index.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of shift_sequencer_if (commands in, response out)
//   busy  : high whenever the sequencer is not idle
module shift_sequencer #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  scan;
  logic [IDW-1:0]  rsp_id_q;
  logic            grant_vld;
  logic            direct;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    work;
  logic [2:0]      sel_op;
  logic [2:0]      sel_amt;
  logic [2:0]      op_q;
  logic [2:0]      cnt;
  logic [NREQ-1:0] ready;

  // One bit position of the selected operation.
  function automatic logic [W-1:0] shift_step(input logic [W-1:0] v,
                                              input logic [2:0] op);
    logic [W-1:0] r;
    case (op)
      3'b001, 3'b011: r = {v[W-2:0], 1'b0};
      3'b010:         r = {1'b0, v[W-1:1]};
      3'b100:         r = {v[W-1], v[W-1:1]};
      3'b101:         r = {v[W-2:0], v[W-1]};
      3'b110:         r = {v[0], v[W-1:1]};
      default:        r = v;
    endcase
    return r;
  endfunction

  // Round-robin scan: first valid requester at or above ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    sel_data  = '0;
    sel_op    = '0;
    sel_amt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = IDW'((int'(ptr) + i) % NREQ);
      if (!grant_vld && bus.req_valid[scan]) begin
        grant_vld = 1'b1;
        grant_idx = scan;
        sel_data  = bus.req_data[int'(scan)*W +: W];
        sel_op    = bus.req_op[int'(scan)*3 +: 3];
        sel_amt   = bus.req_amt[int'(scan)*3 +: 3];
      end
    end
  end

  // Pass, invalid and zero-amount commands skip the shift loop entirely.
  assign direct = (sel_amt == 3'd0) || (sel_op == 3'b000) || (sel_op == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = direct ? RESP : SHIFT;
      SHIFT:   if (cnt == 3'd1) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = '0;
    if (state == IDLE && grant_vld) ready[grant_idx] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = work;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

  // Capture on the grant edge, then iterate the working register in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      work     <= '0;
      op_q     <= '0;
      rsp_id_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_q     <= sel_op;
            rsp_id_q <= grant_idx;
            ptr      <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            work     <= (sel_op == 3'b111) ? '0 : sel_data;
            cnt      <= direct ? 3'd0 : sel_amt;
          end
        end
        SHIFT: begin
          work <= shift_step(work, op_q);
          cnt  <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
